// File: rtl/bridge_pkg.sv
// Shared encodings for cache_axi_bridge_n: client request types, AXI constants,
// read/write FSM states and the request-type to AXI size mapping.
package bridge_pkg;

    localparam logic [2:0] RT_BYTE = 3'b000;
    localparam logic [2:0] RT_HALF = 3'b001;
    localparam logic [2:0] RT_WORD = 3'b010;
    localparam logic [2:0] RT_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_1B    = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B    = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic {R_IDLE, R_ADDR} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    // Line and word requests both move 32-bit beats.
    function automatic logic [2:0] axi_size(input logic [2:0] t);
        case (t)
            RT_BYTE: return AXI_SIZE_1B;
            RT_HALF: return AXI_SIZE_2B;
            default: return AXI_SIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among enabled requests, searching from the
// client after the last winner; the pointer moves only when a grant is issued.
module rr_arbiter #(
    parameter int NUM = 2,
    parameter int PW  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [NUM-1:0] req,
    input  logic           enable,
    output logic [NUM-1:0] grant,
    output logic [PW-1:0]  gidx
);

    logic [PW-1:0]  last;
    logic [NUM-1:0] req_e;
    logic           found;

    assign req_e = req & {NUM{enable}};

    // First pass covers clients above the last winner, second pass wraps around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (!found && req_e[i] && i > int'(last)) begin
                grant[i] = 1'b1;
                gidx     = PW'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM; i++) begin
            if (!found && req_e[i]) begin
                grant[i] = 1'b1;
                gidx     = PW'(i);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)     last <= PW'(NUM - 1);
        else if (found) last <= gidx;
    end

endmodule

// File: rtl/cache_axi_bridge_n.sv
// NUM_RD cache read clients plus one line write-back client onto one AXI3 master.
// Define BRIDGE_RAW_CHECK_EN to hold off reads that hit the line being written back.
module cache_axi_bridge_n
    import bridge_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [3*NUM_RD-1:0]        rd_type,
    input  logic [ADDR_W*NUM_RD-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_rdy,
    output logic [NUM_RD-1:0]          ret_valid,
    output logic [NUM_RD-1:0]          ret_last,
    output logic [31:0]                ret_data,
    input  logic                       wr_req,
    input  logic [2:0]                 wr_type,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [3:0]                 wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]   wr_data,
    output logic                       wr_rdy,
    output logic [3:0]                 arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic [3:0]                 awid,
    output logic [ADDR_W-1:0]          awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [3:0]                 wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic [3:0]                 bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int         PW       = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int         OFF_W    = $clog2(4 * LINE_WORDS);
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    r_state_t                  r_state;
    w_state_t                  w_state;
    logic [NUM_RD-1:0]         outst, blocked, eligible, grant;
    logic [PW-1:0]             gidx;
    logic [ADDR_W-1:0]         sel_addr;
    logic [2:0]                sel_type;
    logic [32*LINE_WORDS-1:0]  wbuf;
    logic [7:0]                wcnt;
    logic [31:0]               nxt_word;
    logic                      unused_resp;

    assign unused_resp = ^{rresp, bresp, bid};

    assign arburst = AXI_BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign awid    = '0;
    assign wid     = '0;

`ifdef BRIDGE_RAW_CHECK_EN
    // awaddr holds the buffered line address for the whole write transaction.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_RD; i++)
            blocked[i] = (w_state != W_IDLE) &&
                (rd_addr[i*ADDR_W+OFF_W +: ADDR_W-OFF_W] == awaddr[ADDR_W-1:OFF_W]);
    end
`else
    assign blocked = '0;
`endif

    assign eligible = rd_req & ~outst & ~blocked;

    rr_arbiter #(.NUM(NUM_RD), .PW(PW)) u_arb (
        .aclk   (aclk),
        .areset (areset),
        .req    (eligible),
        .enable (rready && r_state == R_IDLE),
        .grant  (grant),
        .gidx   (gidx)
    );

    assign rd_rdy = grant;

    always_comb begin
        sel_addr = '0;
        sel_type = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (grant[i]) begin
                sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
                sel_type = rd_type[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arid    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (|grant) begin
                    arvalid <= 1'b1;
                    araddr  <= sel_addr;
                    arsize  <= axi_size(sel_type);
                    arlen   <= (sel_type == RT_LINE) ? LINE_LEN : 8'd0;
                    arid    <= 4'(gidx);
                    r_state <= R_ADDR;
                end
                R_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // rready doubles as the "out of reset" flag gating every ready/valid output.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            outst  <= '0;
            rready <= 1'b0;
        end else begin
            rready <= 1'b1;
            for (int i = 0; i < NUM_RD; i++) begin
                if (arvalid && arready && arid == 4'(i))
                    outst[i] <= 1'b1;
                else if (rvalid && rready && rlast && rid == 4'(i))
                    outst[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        ret_valid = '0;
        for (int i = 0; i < NUM_RD; i++)
            ret_valid[i] = rready && rvalid && rid == 4'(i);
    end

    assign ret_last = ret_valid & {NUM_RD{rlast}};
    assign ret_data = rdata;

    assign wr_rdy = rready && w_state == W_IDLE;

    always_comb begin
        nxt_word = '0;
        for (int i = 0; i < LINE_WORDS; i++)
            if (8'(i) == wcnt + 8'd1) nxt_word = wbuf[i*32 +: 32];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            wbuf    <= '0;
            wcnt    <= '0;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wlast   <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (wr_req && wr_rdy) begin
                    wbuf    <= wr_data;
                    awaddr  <= wr_addr;
                    awsize  <= axi_size(wr_type);
                    awlen   <= (wr_type == RT_LINE) ? LINE_LEN : 8'd0;
                    wstrb   <= (wr_type == RT_LINE) ? 4'hF : wr_wstrb;
                    awvalid <= 1'b1;
                    w_state <= W_ADDR;
                end
                W_ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    wcnt    <= '0;
                    wdata   <= wbuf[31:0];
                    wlast   <= (awlen == 8'd0);
                    w_state <= W_DATA;
                end
                W_DATA: if (wready) begin
                    if (wcnt == awlen) begin
                        wvalid  <= 1'b0;
                        wlast   <= 1'b0;
                        bready  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        wcnt  <= wcnt + 8'd1;
                        wdata <= nxt_word;
                        wlast <= (wcnt + 8'd1 == awlen);
                    end
                end
                W_RESP: if (bvalid) begin
                    bready  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge_n.sv
// Self-checking bench for cache_axi_bridge_n (NUM_RD=2, LINE_WORDS=4): vector table,
// hand-written handshake sequences and a randomized return-routing phase.
module tb_cache_axi_bridge_n;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int LW = 4;

    logic aclk = 1'b0;
    logic areset;
    logic [NR-1:0] rd_req, rd_rdy, ret_valid, ret_last;
    logic [3*NR-1:0] rd_type;
    logic [AW*NR-1:0] rd_addr;
    logic [31:0] ret_data;
    logic wr_req, wr_rdy;
    logic [2:0] wr_type;
    logic [AW-1:0] wr_addr;
    logic [3:0] wr_wstrb;
    logic [32*LW-1:0] wr_data;
    logic [3:0] arid, rid, awid, wid, bid, arcache, awcache, wstrb;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic [31:0] rdata, wdata;
    logic wlast, wvalid, wready, bvalid, bready;

    cache_axi_bridge_n #(.NUM_RD(NR), .ADDR_W(AW), .LINE_WORDS(LW)) dut (
        .aclk(aclk), .areset(areset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [7:0]  len;
    } rd_vec_t;

    typedef struct {
        logic        rdy;
        logic [31:0] data;
        logic        last;
    } w_vec_t;

    rd_vec_t tv[4];
    w_vec_t  wv[5];
    int      exp_ids[4];
    logic [NR-1:0] m_outst, probe, exp_v;

    // Re-issue line reads on both clients until each has one read in flight.
    task automatic arm_both();
        rd_type = {3'b100, 3'b100};
        rd_addr = {32'h0000_8000, 32'h0000_9000};
        rvalid  = 1'b0;
        rd_req  = 2'b11;
        arready = 1'b1;
        repeat (6) @(negedge aclk);
        rd_req  = 2'b00;
        arready = 1'b0;
        m_outst = 2'b11;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        m_outst = '0;

        tv[0] = '{3'b100, 32'h1C00_0010, 3'd2, 8'd3};
        tv[1] = '{3'b000, 32'h0000_0103, 3'd0, 8'd0};
        tv[2] = '{3'b001, 32'h0000_0202, 3'd1, 8'd0};
        tv[3] = '{3'b010, 32'h0000_0304, 3'd2, 8'd0};
        wv[0] = '{1'b1, 32'hAAAA_0001, 1'b0};
        wv[1] = '{1'b0, 32'hBBBB_0002, 1'b0};
        wv[2] = '{1'b1, 32'hBBBB_0002, 1'b0};
        wv[3] = '{1'b1, 32'hCCCC_0003, 1'b0};
        wv[4] = '{1'b1, 32'hDDDD_0004, 1'b1};
        exp_ids = '{1, 0, 1, 0};

        // Reset state, with requests and a response beat presented.
        repeat (3) @(negedge aclk);
        rd_req = 2'b11; wr_req = 1'b1; rvalid = 1'b1; #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rd_rdy", rd_rdy, 0);
        chk("rst_wr_rdy", wr_rdy, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_addrs", {araddr, awaddr}, 0);
        chk("rst_wdata", wdata, 0);
        chk("consts", {arburst, arlock, arcache, arprot, awburst, awlock, awcache, awprot, awid, wid},
            {2'b01, 2'b00, 4'h0, 3'h0, 2'b01, 2'b00, 4'h0, 3'h0, 4'h0, 4'h0});
        rd_req = '0; wr_req = 1'b0; rvalid = 1'b0;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_rready", rready, 1);
        chk("post_rst_wr_rdy", wr_rdy, 1);

        // Single-client reads: size/len per request type, beats routed to client 0.
        for (int k = 0; k < 4; k++) begin
            rd_type = {3'b000, tv[k].t};
            rd_addr = {32'h0, tv[k].a};
            rd_req  = 2'b01; #1;
            chk("tbl_rd_rdy", rd_rdy, 2'b01);
            @(negedge aclk);
            rd_req = 2'b00;
            chk("tbl_arvalid", arvalid, 1);
            chk("tbl_araddr", araddr, tv[k].a);
            chk("tbl_arsize", arsize, tv[k].sz);
            chk("tbl_arlen", arlen, tv[k].len);
            chk("tbl_arid", arid, 0);
            arready = 1'b1;
            @(negedge aclk);
            arready = 1'b0;
            chk("tbl_arvalid_drop", arvalid, 0);
            for (int b = 0; b <= int'(tv[k].len); b++) begin
                rvalid = 1'b1; rid = 4'd0; rdata = $urandom;
                rlast = (b == int'(tv[k].len)); #1;
                chk("tbl_ret_valid", ret_valid, 2'b01);
                chk("tbl_ret_last", ret_last, {1'b0, rlast});
                chk("tbl_ret_data", ret_data, rdata);
                @(negedge aclk);
            end
            rvalid = 1'b0; rlast = 1'b0;
        end

        // Two clients competing: client 1 first alone, then both; grants alternate.
        rd_type = {3'b010, 3'b010};
        rd_addr = {32'h2000_0004, 32'h2000_0000};
        rd_req  = 2'b10;
        for (int n = 0; n < 4; n++) begin
            int w;
            w = 0;
            while (!arvalid && w < 20) begin
                @(negedge aclk);
                w++;
            end
            chk("alt_arvalid", arvalid, 1);
            chk("alt_arid", arid, 4'(exp_ids[n]));
            chk("alt_arsize", arsize, 2);
            chk("alt_arlen", arlen, 0);
            arready = 1'b1;
            @(negedge aclk);
            arready = 1'b0;
            rvalid = 1'b1; rid = 4'(exp_ids[n]); rlast = 1'b1; rdata = $urandom;
            rd_req = (n == 3) ? 2'b00 : 2'b11;
            @(negedge aclk);
            rvalid = 1'b0; rlast = 1'b0;
        end
        // Last winner was client 0: both requesting offers client 1, and holds without accept.
        rd_req = 2'b11; #1;
        chk("rr_next", rd_rdy, 2'b10);
        rd_req = 2'b00;
        @(negedge aclk);
        rd_req = 2'b11; #1;
        chk("rr_hold", rd_rdy, 2'b10);
        rd_req = 2'b00;

        // Line write with a W stall on the second beat.
        wr_type = 3'b100; wr_addr = 32'h0000_1000; wr_wstrb = 4'h0;
        wr_data = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        wr_req = 1'b1; #1;
        chk("wr_rdy_idle", wr_rdy, 1);
        @(negedge aclk);
        wr_req = 1'b0;
        chk("wr_awvalid", awvalid, 1);
        chk("wr_awaddr", awaddr, 32'h0000_1000);
        chk("wr_awlen", awlen, 3);
        chk("wr_awsize", awsize, 2);
        chk("wr_rdy_busy", wr_rdy, 0);
        chk("wr_wvalid_early", wvalid, 0);
        awready = 1'b1;
        @(negedge aclk);
        awready = 1'b0;
        chk("wr_awvalid_drop", awvalid, 0);
        for (int c = 0; c < 5; c++) begin
            wready = wv[c].rdy;
            chk("wr_wvalid", wvalid, 1);
            chk("wr_wdata", wdata, wv[c].data);
            chk("wr_wlast", wlast, wv[c].last);
            chk("wr_wstrb", wstrb, 4'hF);
            @(negedge aclk);
        end
        wready = 1'b0;
        chk("wr_wvalid_drop", wvalid, 0);
        chk("wr_bready", bready, 1);
        chk("wr_rdy_resp", wr_rdy, 0);
        bvalid = 1'b1;
        @(negedge aclk);
        bvalid = 1'b0;
        chk("wr_bready_drop", bready, 0);
        chk("wr_rdy_back", wr_rdy, 1);

        // Half-word write: single beat carrying the client's byte strobes.
        wr_type = 3'b001; wr_addr = 32'h0000_1002; wr_wstrb = 4'b1100;
        wr_data = {96'h0, 32'h1234_5678};
        wr_req = 1'b1;
        @(negedge aclk);
        wr_req = 1'b0;
        chk("hw_awsize", awsize, 1);
        chk("hw_awlen", awlen, 0);
        awready = 1'b1;
        @(negedge aclk);
        awready = 1'b0;
        chk("hw_wbeat", {wvalid, wlast, wstrb, wdata}, {1'b1, 1'b1, 4'b1100, 32'h1234_5678});
        wready = 1'b1;
        @(negedge aclk);
        wready = 1'b0;
        chk("hw_bready", bready, 1);
        bvalid = 1'b1;
        @(negedge aclk);
        bvalid = 1'b0;

`ifdef BRIDGE_RAW_CHECK_EN
        // Read to the line being written back waits for B; other lines proceed.
        wr_type = 3'b100; wr_addr = 32'h0000_1000; wr_req = 1'b1;
        @(negedge aclk);
        wr_req = 1'b0;
        rd_type = {3'b010, 3'b010};
        rd_addr = {32'h0000_2000, 32'h0000_1008};
        rd_req = 2'b01; #1;
        chk("raw_block", rd_rdy, 2'b00);
        rd_req = 2'b10; #1;
        chk("raw_other", rd_rdy, 2'b10);
        rd_req = 2'b00;
        awready = 1'b1;
        @(negedge aclk);
        awready = 1'b0; wready = 1'b1;
        repeat (4) @(negedge aclk);
        wready = 1'b0;
        rd_req = 2'b01; #1;
        chk("raw_block_resp", rd_rdy, 2'b00);
        rd_req = 2'b00;
        bvalid = 1'b1;
        @(negedge aclk);
        bvalid = 1'b0;
        rd_req = 2'b01; #1;
        chk("raw_release", rd_rdy, 2'b01);
        rd_req = 2'b00;
`endif

        // Randomized beats (including foreign IDs) against a routing/outstanding model.
        arm_both();
        rd_req = 2'b11; #1;
        chk("rnd_setup_rdy", rd_rdy, 2'b00);
        rd_req = 2'b00;
        for (int c = 0; c < 400; c++) begin
            if (c % 80 == 79) arm_both();
            probe = 2'b01 << $urandom_range(0, 1);
            rd_req = probe; #1;
            chk("rnd_rd_rdy", rd_rdy, probe & ~m_outst);
            rd_req = 2'b00;
            rvalid = 1'($urandom_range(0, 1));
            rid    = 4'($urandom_range(0, 5));
            rlast  = ($urandom_range(0, 3) == 0);
            rdata  = $urandom; #1;
            exp_v = (rvalid && rid < NR) ? (2'b01 << rid) : 2'b00;
            chk("rnd_ret_valid", ret_valid, exp_v);
            chk("rnd_ret_last", ret_last, rlast ? exp_v : 2'b00);
            chk("rnd_ret_data", ret_data, rdata);
            if (rvalid && rlast && rid < NR) m_outst[rid[0]] = 1'b0;
            @(negedge aclk);
        end
        rvalid = 1'b0; rlast = 1'b0;

        // Reset in the middle of a read burst and a write burst.
        rd_type = {3'b000, 3'b100}; rd_addr = {32'h0, 32'h0000_3000};
        wr_type = 3'b100; wr_addr = 32'h0000_4000;
        arm_both();
        rd_req = 2'b00;
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
        @(negedge aclk);
        rvalid = 1'b0; rlast = 1'b0;
        rd_req = 2'b01; rd_type = {3'b000, 3'b100}; rd_addr = {32'h0, 32'h0000_3000};
        wr_req = 1'b1;
        @(negedge aclk);
        rd_req = 2'b00; wr_req = 1'b0;
        chk("mid_valids", {arvalid, awvalid}, 2'b11);
        arready = 1'b1; awready = 1'b1;
        @(negedge aclk);
        arready = 1'b0; awready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b0;
        @(negedge aclk);
        chk("mid_wvalid", wvalid, 1);
        rd_req = 2'b11; wr_req = 1'b1;
        areset = 1'b1; #1;
        chk("mid_rst_all", {arvalid, awvalid, wvalid, bready, rready, rd_rdy, wr_rdy, ret_valid}, 0);
        @(negedge aclk);
        rvalid = 1'b0; rd_req = 2'b00; wr_req = 1'b0;
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        rd_type = {3'b000, 3'b100}; rd_addr = {32'h0, 32'h0000_5000};
        rd_req = 2'b01; #1;
        chk("post_mid_rd_rdy", rd_rdy, 2'b01);
        @(negedge aclk);
        rd_req = 2'b00;
        chk("post_mid_arvalid", arvalid, 1);
        chk("post_mid_araddr", araddr, 32'h0000_5000);
        chk("post_mid_arlen", arlen, 3);
        arready = 1'b1;
        @(negedge aclk);
        arready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
